// File: rtl/i2c_target_frontend_if.sv
// Pin-level and byte-delivery signals of the I2C target front end.
// slave = the front end itself, master = bus model / downstream consumer.
interface i2c_target_frontend_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] data_byte;
  logic       data_valid;
  logic       start_pulse;
  logic       stop_pulse;
  logic       addressed;

  modport slave (
    input  scl_in, sda_in,
    output sda_oe, data_byte, data_valid, start_pulse, stop_pulse, addressed
  );

  modport master (
    output scl_in, sda_in,
    input  sda_oe, data_byte, data_valid, start_pulse, stop_pulse, addressed
  );
endinterface

// File: rtl/i2c_target_frontend.sv
// Bit-level I2C write-only target: sync, START/STOP detect, address match, byte shift, ACK.
// Define I2C_GLITCH_FILTER_EN to add a 3-sample glitch filter after the synchronisers.
module i2c_target_frontend #(
  parameter logic [6:0] TARGET_ADDR = 7'h2A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  i2c_target_frontend_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE} state_t;

  // Synchronisers preset high so reset looks like an idle bus.
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.sda_in};
    end
  end

  logic [1:0] raw, line;
  assign raw = {sda_sync[SYNC_STAGES-1], scl_sync[SYNC_STAGES-1]};

`ifdef I2C_GLITCH_FILTER_EN
  // Output follows the input only once three consecutive samples agree.
  logic [1:0] hist0, hist1, flt_q;
  for (genvar i = 0; i < 2; i++) begin : g_flt
    assign line[i] = (raw[i] == hist0[i] && raw[i] == hist1[i]) ? raw[i] : flt_q[i];
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hist0 <= '1;
      hist1 <= '1;
      flt_q <= '1;
    end else begin
      hist0 <= raw;
      hist1 <= hist0;
      flt_q <= line;
    end
  end
`else
  assign line = raw;
`endif

  logic scl_s, sda_s, scl_q, sda_q;
  assign scl_s = line[0];
  assign sda_s = line[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl_s;
      sda_q <= sda_s;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  =  scl_s & ~scl_q;
  assign scl_fall  = ~scl_s &  scl_q;
  assign start_det =  scl_s &  scl_q &  sda_q & ~sda_s;
  assign stop_det  =  scl_s &  scl_q & ~sda_q &  sda_s;

  state_t     state, state_n;
  logic [2:0] bit_cnt, bit_cnt_n;
  logic [7:0] shift, shift_n;
  logic       ack_drive, ack_n;
  logic       addressed_n, valid_n, start_n, stop_n;
  logic [7:0] byte_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      bit_cnt         <= '0;
      shift           <= '0;
      ack_drive       <= 1'b0;
      bus.addressed   <= 1'b0;
      bus.data_byte   <= '0;
      bus.data_valid  <= 1'b0;
      bus.start_pulse <= 1'b0;
      bus.stop_pulse  <= 1'b0;
    end else begin
      state           <= state_n;
      bit_cnt         <= bit_cnt_n;
      shift           <= shift_n;
      ack_drive       <= ack_n;
      bus.addressed   <= addressed_n;
      bus.data_byte   <= byte_n;
      bus.data_valid  <= valid_n;
      bus.start_pulse <= start_n;
      bus.stop_pulse  <= stop_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    if (start_det) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
    end else if (stop_det) begin
      state_n   = IDLE;
      bit_cnt_n = '0;
    end else begin
      case (state)
        ADDR, DATA: if (scl_rise) begin
          shift_n   = {shift[6:0], sda_s};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (state == DATA)
              state_n = DATA_ACK;
            else if (shift_n[7:1] == TARGET_ADDR && !shift_n[0])
              state_n = ADDR_ACK;
            else
              state_n = IGNORE;
          end
        end
        // Second SCL fall of the ACK phase closes the 9th clock.
        ADDR_ACK, DATA_ACK: if (scl_fall && ack_drive) begin
          state_n   = DATA;
          bit_cnt_n = '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_n       = ack_drive;
    addressed_n = bus.addressed;
    byte_n      = bus.data_byte;
    valid_n     = 1'b0;
    start_n     = start_det;
    stop_n      = stop_det & ~start_det;
    if (start_det || stop_det) begin
      ack_n       = 1'b0;
      addressed_n = 1'b0;
    end else begin
      case (state)
        ADDR_ACK, DATA_ACK: if (scl_fall) begin
          ack_n = ~ack_drive;
          if (!ack_drive) addressed_n = 1'b1;
        end
        DATA: if (scl_rise && bit_cnt == 3'd7) begin
          byte_n  = {shift[6:0], sda_s};
          valid_n = 1'b1;
        end
        default: ack_n = 1'b0;
      endcase
    end
  end

  // Release SDA in the very cycle a bus condition or reset is seen, not one later.
  assign bus.sda_oe = ack_drive & ~(start_det | stop_det | reset);

endmodule

// File: tb/tb_i2c_target_frontend.sv
// Directed bench: bus-master model drives write transfers, monitor tallies DUT pulses.
module tb_i2c_target_frontend;
  localparam int H = 12;
  localparam int Q = 6;

  logic clk = 1'b0;
  logic reset;
  logic scl_m, sda_m;
  always #5 clk = ~clk;

  i2c_target_frontend_if bus ();
  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_target_frontend #(.TARGET_ADDR(7'h2A), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vecs = 0;
  int errs = 0;
  int dv_cnt = 0, st_cnt = 0, sp_cnt = 0, oe_cnt = 0, ad_cnt = 0;
  logic [7:0] bytes[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.data_valid) begin
        dv_cnt++;
        bytes.push_back(bus.data_byte);
      end
      if (bus.start_pulse) st_cnt++;
      if (bus.stop_pulse)  sp_cnt++;
      if (bus.sda_oe)      oe_cnt++;
      if (bus.addressed)   ad_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; wait_clk(H);
    scl_m = 1'b1; wait_clk(H);
    sda_m = 1'b1; wait_clk(H);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(H);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  // ack_low = SDA seen low mid-way through the 9th SCL high phase.
  task automatic send_byte(input logic [7:0] b, output logic ack_low);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(H / 2);
    ack_low = (bus.sda_in == 1'b0);
    wait_clk(H / 2);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  initial begin
    int dv0, st0, sp0, oe0, ad0, nb;
    logic ack;
    reset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    wait_clk(3);
    chk("rst_sda_oe", bus.sda_oe, 0);
    chk("rst_data_byte", bus.data_byte, 8'h00);
    chk("rst_data_valid", bus.data_valid, 0);
    chk("rst_start", bus.start_pulse, 0);
    chk("rst_stop", bus.stop_pulse, 0);
    chk("rst_addressed", bus.addressed, 0);
    reset = 1'b0;
    wait_clk(H);

    // Write 0x2A, 0xA5, STOP
    dv0 = dv_cnt; st0 = st_cnt; sp0 = sp_cnt; nb = bytes.size();
    start_cond();
    send_byte(8'h54, ack);
    chk("t1_addr_ack", ack, 1);
    chk("t1_addressed", bus.addressed, 1);
    send_byte(8'hA5, ack);
    chk("t1_data_ack", ack, 1);
    stop_cond();
    wait_clk(H);
    chk("t1_dv_count", dv_cnt - dv0, 1);
    chk("t1_byte", bytes[nb], 8'hA5);
    chk("t1_data_byte_hold", bus.data_byte, 8'hA5);
    chk("t1_start_count", st_cnt - st0, 1);
    chk("t1_stop_count", sp_cnt - sp0, 1);
    chk("t1_addressed_fell", bus.addressed, 0);

    // Address 0x2B write, then 3 bytes into IGNORE
    dv0 = dv_cnt; oe0 = oe_cnt; ad0 = ad_cnt;
    start_cond();
    send_byte(8'h56, ack);
    chk("t2_addr_nack", ack, 0);
    send_byte(8'h12, ack);
    send_byte(8'h34, ack);
    send_byte(8'h00, ack);
    chk("t2_data_nack", ack, 0);
    stop_cond();
    wait_clk(H);
    chk("t2_oe_cycles", oe_cnt - oe0, 0);
    chk("t2_dv_count", dv_cnt - dv0, 0);
    chk("t2_addressed_cycles", ad_cnt - ad0, 0);

    // Address 0x2A read request
    dv0 = dv_cnt; ad0 = ad_cnt;
    start_cond();
    send_byte(8'h55, ack);
    chk("t3_read_nack", ack, 0);
    send_byte(8'hC3, ack);
    stop_cond();
    wait_clk(H);
    chk("t3_dv_count", dv_cnt - dv0, 0);
    chk("t3_addressed_cycles", ad_cnt - ad0, 0);

    // 0x01, 0xFF, repeated START, 0x3C
    dv0 = dv_cnt; st0 = st_cnt; nb = bytes.size();
    start_cond();
    send_byte(8'h54, ack); chk("t4_addr1_ack", ack, 1);
    send_byte(8'h01, ack); chk("t4_d01_ack", ack, 1);
    send_byte(8'hFF, ack); chk("t4_dff_ack", ack, 1);
    start_cond();
    chk("t4_addressed_after_rs", bus.addressed, 0);
    send_byte(8'h54, ack); chk("t4_addr2_ack", ack, 1);
    send_byte(8'h3C, ack); chk("t4_d3c_ack", ack, 1);
    stop_cond();
    wait_clk(H);
    chk("t4_dv_count", dv_cnt - dv0, 3);
    chk("t4_byte0", bytes[nb], 8'h01);
    chk("t4_byte1", bytes[nb+1], 8'hFF);
    chk("t4_byte2", bytes[nb+2], 8'h3C);
    chk("t4_start_count", st_cnt - st0, 2);

    // Partial byte then STOP; then reset during address ACK
    dv0 = dv_cnt; sp0 = sp_cnt;
    start_cond();
    send_byte(8'h54, ack);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    stop_cond();
    wait_clk(H);
    chk("t5_partial_dv", dv_cnt - dv0, 0);
    chk("t5_stop_count", sp_cnt - sp0, 1);
    chk("t5_data_byte_kept", bus.data_byte, 8'h3C);
    start_cond();
    for (int i = 7; i >= 0; i--) send_bit(i == 0 ? 1'b0 : 1'b1 & (8'h54 >> i));
    sda_m = 1'b1;
    for (int i = 0; i < 40 && !bus.sda_oe; i++) @(negedge clk);
    chk("t5_oe_before_reset", bus.sda_oe, 1);
    chk("t5_addressed_before_reset", bus.addressed, 1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t5_rst_sda_oe", bus.sda_oe, 0);
    chk("t5_rst_data_byte", bus.data_byte, 8'h00);
    chk("t5_rst_addressed", bus.addressed, 0);
    chk("t5_rst_valid", bus.data_valid, 0);
    chk("t5_rst_pulses", {bus.start_pulse, bus.stop_pulse}, 2'b00);
    reset = 1'b0;
    scl_m = 1'b1;
    wait_clk(H);

    // 1-clk SDA low glitch with SCL high
    st0 = st_cnt; sp0 = sp_cnt;
    sda_m = 1'b0; wait_clk(1);
    sda_m = 1'b1; wait_clk(H);
`ifdef I2C_GLITCH_FILTER_EN
    chk("t6_glitch_start", st_cnt - st0, 0);
    chk("t6_glitch_stop", sp_cnt - sp0, 0);
`else
    chk("t6_glitch_start", st_cnt - st0, 1);
    chk("t6_glitch_stop", sp_cnt - sp0, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/i2c_target_frontend.md
Name: i2c_target_frontend

Overview:
- Bit-level I2C target front end for the hasher datapath. Sits upstream of byte assembly and hashing.
- Synchronises SCL/SDA, detects START/STOP, matches the 7-bit target address (write only), shifts in data bits and ACKs each byte.
- Delivers each completed data byte as a one-cycle valid pulse to the downstream hash stage.

Parameters:
- TARGET_ADDR, 7'h2A, 7-bit I2C address this target answers to.
- SYNC_STAGES, 2, flop stages on scl_in/sda_in before edge detection (min 2).

Ports:
- clk  input  1  system clock, >= 8x SCL rate
- reset  input  1  synchronous, active-high
- scl_in  input  1  raw SCL pin level
- sda_in  input  1  raw SDA pin level
- sda_oe  output  1  1 = pull SDA low (ACK); open-drain enable
- data_byte  output  8  last received data byte, MSB first on bus
- data_valid  output  1  one-cycle pulse; data_byte valid this cycle
- start_pulse  output  1  one-cycle pulse on START or repeated START
- stop_pulse  output  1  one-cycle pulse on STOP
- addressed  output  1  high from address ACK until STOP/START

Behaviour:
- Reset (clk, reset: synchronous, active-high): sda_oe=0, data_byte=8'h00, data_valid=0, start_pulse=0, stop_pulse=0, addressed=0. State=IDLE, bit_cnt=0. Synchroniser flops preset to 1 (idle bus).
- Edges use the synchronised lines (scl_s, sda_s) against a one-flop history.
  - SCL rise: scl_s=1, prev=0. SCL fall: scl_s=0, prev=1.
  - START: sda_s falls while scl_s=1 and prev scl=1.
  - STOP: sda_s rises while scl_s=1 and prev scl=1.
- START and STOP take priority over bit sampling in the same cycle.
- States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, IGNORE.
- IDLE: START -> ADDR, bit_cnt=0, start_pulse=1 for one cycle.
- ADDR: each SCL rise shifts sda_s into shift[0] and increments bit_cnt (0..7).
  - After the 8th bit: shift[7:1]==TARGET_ADDR and shift[0]==0 (write) -> ADDR_ACK.
  - Otherwise (address mismatch, or read request with R/W=1) -> IGNORE. No ACK; sda_oe stays 0.
- ADDR_ACK:
  - Next SCL fall sets sda_oe=1 and addressed=1.
  - The following SCL fall (end of 9th clock) sets sda_oe=0 -> DATA, bit_cnt=0.
- DATA: same shifting as ADDR.
  - On the 8th SCL rise: data_byte<=shift value including the bit just sampled; data_valid=1 in the next cycle only; -> DATA_ACK.
- DATA_ACK: same timing as ADDR_ACK; returns to DATA. Every data byte is ACKed; no backpressure.
- IGNORE: sda_oe=0; waits for START or STOP.
- Repeated START in any state -> ADDR.
  - sda_oe released same cycle; addressed=0; bit_cnt=0; start_pulse=1.
- STOP in any state -> IDLE.
  - sda_oe=0, addressed=0, stop_pulse=1.
  - Partial byte (bit_cnt 1..7) discarded, no data_valid.
- data_byte holds its value until overwritten by the next completed byte. It is not cleared by START or STOP.
- reset mid-transfer: immediate return to reset values; sda_oe releases in that cycle.
- bit_cnt is 3 bits; 8th bit is detected as bit_cnt==7 at an SCL rise, then bit_cnt wraps to 0.
- Latency: SCL rise at pin -> sample = SYNC_STAGES+1 clk; data_valid one clk after that sample.

Optional Feature:
- Macro I2C_GLITCH_FILTER_EN.
- Defined:
  - Each synchronised line passes through a filter that updates only after 3 consecutive identical samples.
  - Pulses shorter than 3 clk are rejected.
  - Adds 2 clk latency to all edges.
- Undefined: synchroniser output is used directly; no extra latency.

Test Plan:
- Write to 0x2A, data 8'hA5, STOP -> ACK low on 9th SCL both bytes; data_valid pulses once with data_byte=8'hA5; stop_pulse once; addressed falls.
- Address 0x2B write -> no ACK (sda_oe never 1); state IGNORE; no data_valid even if 3 further bytes are clocked.
- Address 0x2A with R/W=1 -> NACK, no data_valid, addressed stays 0.
- Write 0x2A, bytes 8'h01, 8'hFF, repeated START, address 0x2A, 8'h3C -> three data_valid pulses with 8'h01, 8'hFF, 8'h3C; start_pulse twice.
- STOP after 4 data bits, then reset asserted while sda_oe=1 in a new transfer -> no data_valid for partial byte; sda_oe=0 and all outputs at reset values the cycle after reset.
- With I2C_GLITCH_FILTER_EN: 1-clk low glitch on SDA while SCL high -> no start_pulse. Without the macro: same glitch -> start_pulse.
